ula_ncl_sequencer: RTL and testbench
====================================

# ula_ncl_sequencer

Synchronous controller that sequences the dual-rail NCL ULA (adder/subtractor, logic ops, overflow detector) from a clocked valid/ready request port. It latches one operation, drives it into the ULA as a DATA wavefront, waits for synchronized completion, captures result and overflow, and then drives a NULL wavefront and waits for the ULA to return to all-NULL. The captured response is returned on a valid/ready port. The block sits between the clocked host datapath and the asynchronous ULA. It is the only driver of the ULA inputs.

## Interface
Parameters:
- WIDTH, 4, operand/result width in bits (single-rail)
- TIMEOUT, 255, maximum cycles spent waiting in any wavefront phase; 8-bit counter, 1..255

Ports (dual-rail pair i: rail1/true at [2i+1], rail0/false at [2i]):
- clk  in  1  single clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when both high at rising edge
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_op  in  2  00 ADD, 01 SUB, 10 AND, 11 OR
- ula_a  out  2*WIDTH  dual-rail A to ULA
- ula_b  out  2*WIDTH  dual-rail B to ULA
- ula_sel0  out  2  dual-rail req_op[0]
- ula_sel1  out  2  dual-rail req_op[1]
- ula_res  in  2*WIDTH  dual-rail result from ULA (asynchronous)
- ula_ovf  in  2  dual-rail overflow from ULA (asynchronous)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both high at rising edge
- rsp_res  out  WIDTH  captured result (rail1 bits)
- rsp_ovf  out  1  captured overflow; forced 0 for AND/OR
- rsp_err  out  1  timeout or illegal code (both rails high) during this operation

## Operation
Synchronizer:
- All ula_res and ula_ovf rails pass through a 2-flop synchronizer. All decisions use stage 2 only.
- complete: every pair has exactly one rail high.
- null: every rail is low.
- illegal: any pair has both rails high.

All ula_* outputs are registered.

FSM states: FLUSH, IDLE, DATA, NULLW, RESP.
- FLUSH (entered on reset): drive NULL; req_ready=0. Go to IDLE when null is seen or when cnt==TIMEOUT. No error is reported in FLUSH.
- IDLE: req_ready=1; drive NULL.
  - On accept: latch a, b, op; load ula_* with the DATA encoding (bit=1 gives 10, bit=0 gives 01); clear cnt, err; go to DATA.
- DATA: hold the DATA encoding; cnt++.
  - complete and not illegal: capture rsp_res = rail1 bits, rsp_ovf = ovf rail1 AND (op is ADD/SUB); go to NULLW.
  - illegal: set err; capture zeros; go to NULLW.
  - cnt==TIMEOUT: set err; capture zeros; go to NULLW.
  - illegal has priority over complete.
- NULLW: drive NULL (registered at entry); cnt cleared on entry, cnt++.
  - null: go to RESP.
  - cnt==TIMEOUT: set err; go to RESP.
- RESP: rsp_valid=1; outputs stable. On rsp_ready go to IDLE; req_ready rises the next cycle. No request is accepted while in RESP.

Only one operation is in flight. req_* is ignored outside IDLE.

## Timing
Reset values (first edge with rst_n=0):
- state=FLUSH, req_ready=0, rsp_valid=0, rsp_res=0, rsp_ovf=0, rsp_err=0.
- All ula_* = 0 (NULL); synchronizer flops=0; cnt=0.

Reset asserted mid-operation abandons the operation immediately, with no response. FLUSH guarantees the ULA is NULL before the next accept.

Minimum latency, with the ULA settling within one cycle:
- E0: accept; DATA driven after E0.
- E1, E2: synchronizer stages.
- E3: capture; NULL driven.
- E4, E5: synchronizer stages.
- E6: enter RESP. rsp_valid is high after E6 (6 cycles).
- With rsp_ready held high, req_ready is high again after E8.

Timeout: err set at the edge where cnt reaches TIMEOUT in DATA or NULLW. Worst case ~2*TIMEOUT+2 cycles to RESP.

req_valid may drop without acceptance. rsp_valid and the rsp data never change while rsp_valid=1 and rsp_ready=0.

## Test plan
- Reset, ULA model idle: after ≤3 cycles FLUSH→IDLE, req_ready=1, all ula_*=0.
- ADD a=0111 b=0001 (WIDTH 4), model returns res=1000, ovf=1: rsp_res=1000, rsp_ovf=1, rsp_err=0, rsp_valid 6 cycles after accept; ula_a=01_10_10_10 during DATA.
- AND a=1100 b=1010, model asserts ovf rail1: rsp_res=1000, rsp_ovf=0 (forced).
- Model never completes in DATA, TIMEOUT=8: rsp_err=1, rsp_res=0, reached within 2*8+3 cycles; the next op succeeds with err=0.
- Model drives both rails of res[2]: rsp_err=1. Separately, hold rsp_ready=0 for 10 cycles: rsp fields stable, req_ready=0 throughout.
- Deassert rst_n during DATA while the model holds DATA results: no rsp_valid; FLUSH waits until the model goes NULL before req_ready=1.

Source files
------------

// File: rtl/ula_ncl_sequencer.sv
// Clocked valid/ready front end for the dual-rail NCL ULA.
// Drives DATA/NULL wavefronts and captures the synchronized result.
module ula_ncl_sequencer #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic [1:0]         req_op,
  output logic [2*WIDTH-1:0] ula_a,
  output logic [2*WIDTH-1:0] ula_b,
  output logic [1:0]         ula_sel0,
  output logic [1:0]         ula_sel1,
  input  logic [2*WIDTH-1:0] ula_res,
  input  logic [1:0]         ula_ovf,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_res,
  output logic               rsp_ovf,
  output logic               rsp_err
);

  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    DATA,
    NULLW,
    RESP
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);
  localparam int unsigned NP = WIDTH + 1;

  state_t state, stateNext;
  logic [7:0] cnt, cntNext;
  logic [1:0] opQ, opNext;

  logic [2*WIDTH-1:0] resS1, resS2;
  logic [1:0]         ovfS1, ovfS2;
  logic [2*NP-1:0]    syncAll;
  logic isComplete, isNull, isIllegal;

  logic               reqReadyNext;
  logic [2*WIDTH-1:0] ulaANext, ulaBNext;
  logic [1:0]         sel0Next, sel1Next;
  logic [WIDTH-1:0]   rspResNext;
  logic               rspOvfNext, rspErrNext;

  function automatic logic [2*WIDTH-1:0] encode(
    input logic [WIDTH-1:0] v
  );
    logic [2*WIDTH-1:0] e;
    for (int i = 0; i < int'(WIDTH); i++) begin
      e[2*i+1] = v[i];
      e[2*i]   = ~v[i];
    end
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] rail1(
    input logic [2*WIDTH-1:0] d
  );
    logic [WIDTH-1:0] r;
    for (int i = 0; i < int'(WIDTH); i++) begin
      r[i] = d[2*i+1];
    end
    return r;
  endfunction

  assign syncAll   = {ovfS2, resS2};
  assign rsp_valid = (state == RESP);

  // Two-flop synchronizer on every ULA output rail.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resS1 <= '0;
      resS2 <= '0;
      ovfS1 <= '0;
      ovfS2 <= '0;
    end else begin
      resS1 <= ula_res;
      resS2 <= resS1;
      ovfS1 <= ula_ovf;
      ovfS2 <= ovfS1;
    end
  end

  // Wavefront classification of the synchronized rails.
  always_comb begin
    isComplete = 1'b1;
    isNull     = 1'b1;
    isIllegal  = 1'b0;
    for (int i = 0; i < int'(NP); i++) begin
      if (syncAll[2*i+1] == syncAll[2*i]) isComplete = 1'b0;
      if (syncAll[2*i+1] | syncAll[2*i])  isNull     = 1'b0;
      if (syncAll[2*i+1] & syncAll[2*i])  isIllegal  = 1'b1;
    end
  end

  // State, counter and registered output update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FLUSH;
      cnt       <= '0;
      opQ       <= '0;
      req_ready <= 1'b0;
      ula_a     <= '0;
      ula_b     <= '0;
      ula_sel0  <= '0;
      ula_sel1  <= '0;
      rsp_res   <= '0;
      rsp_ovf   <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      opQ       <= opNext;
      req_ready <= reqReadyNext;
      ula_a     <= ulaANext;
      ula_b     <= ulaBNext;
      ula_sel0  <= sel0Next;
      ula_sel1  <= sel1Next;
      rsp_res   <= rspResNext;
      rsp_ovf   <= rspOvfNext;
      rsp_err   <= rspErrNext;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    opNext     = opQ;
    ulaANext   = ula_a;
    ulaBNext   = ula_b;
    sel0Next   = ula_sel0;
    sel1Next   = ula_sel1;
    rspResNext = rsp_res;
    rspOvfNext = rsp_ovf;
    rspErrNext = rsp_err;
    unique case (state)
      FLUSH: begin
        cntNext = cnt + 8'd1;
        // Synchronizer restarts from zero, so a null reading is only
        // trusted once both stages hold real samples.
        if ((isNull && cnt >= 8'd2) || cnt == TMO) begin
          stateNext = IDLE;
          cntNext   = '0;
        end
      end
      IDLE: begin
        if (req_valid && req_ready) begin
          opNext     = req_op;
          ulaANext   = encode(req_a);
          ulaBNext   = encode(req_b);
          sel0Next   = {req_op[0], ~req_op[0]};
          sel1Next   = {req_op[1], ~req_op[1]};
          cntNext    = '0;
          rspErrNext = 1'b0;
          stateNext  = DATA;
        end
      end
      DATA: begin
        cntNext = cnt + 8'd1;
        if (isIllegal || (!isComplete && cnt == TMO)) begin
          rspErrNext = 1'b1;
          rspResNext = '0;
          rspOvfNext = 1'b0;
        end else if (isComplete) begin
          rspResNext = rail1(resS2);
          rspOvfNext = ovfS2[1] & ~opQ[1];
        end
        if (isIllegal || isComplete || cnt == TMO) begin
          ulaANext  = '0;
          ulaBNext  = '0;
          sel0Next  = '0;
          sel1Next  = '0;
          cntNext   = '0;
          stateNext = NULLW;
        end
      end
      NULLW: begin
        cntNext = cnt + 8'd1;
        if (isNull) begin
          stateNext = RESP;
        end else if (cnt == TMO) begin
          rspErrNext = 1'b1;
          stateNext  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) stateNext = IDLE;
      end
      default: stateNext = FLUSH;
    endcase
    // After a response, req_ready waits one IDLE cycle before rising.
    reqReadyNext = (stateNext == IDLE) && (state != RESP);
  end

endmodule

// File: tb/tb_ula_ncl_sequencer.sv
// Directed bench for ula_ncl_sequencer with a behavioural NCL ULA.
// Model modes: 0 normal, 1 never completes, 2 illegal res[2], 3 hold.
module tb_ula_ncl_sequencer;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid, req_ready;
  logic [W-1:0]   req_a, req_b;
  logic [1:0]     req_op;
  logic [2*W-1:0] ula_a, ula_b;
  logic [1:0]     ula_sel0, ula_sel1;
  logic [2*W-1:0] ula_res;
  logic [1:0]     ula_ovf;
  logic           rsp_valid, rsp_ready;
  logic [W-1:0]   rsp_res;
  logic           rsp_ovf, rsp_err;

  int nCmp = 0;
  int nBad = 0;

  logic [1:0]     mode;
  logic           forceOvf1;
  logic [2*W-1:0] heldRes;
  logic [1:0]     heldOvf;

  ula_ncl_sequencer #(.WIDTH(W), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .ula_a(ula_a), .ula_b(ula_b),
    .ula_sel0(ula_sel0), .ula_sel1(ula_sel1),
    .ula_res(ula_res), .ula_ovf(ula_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  logic [W-1:0] ma, mb, mr;
  logic         mv, allData;
  logic [1:0]   mop;

  always_comb begin
    allData = 1'b1;
    ma = '0;
    mb = '0;
    mr = '0;
    mv = 1'b0;
    for (int i = 0; i < W; i++) begin
      ma[i] = ula_a[2*i+1];
      mb[i] = ula_b[2*i+1];
      if (ula_a[2*i+1] == ula_a[2*i]) allData = 1'b0;
      if (ula_b[2*i+1] == ula_b[2*i]) allData = 1'b0;
    end
    if (ula_sel0[1] == ula_sel0[0]) allData = 1'b0;
    if (ula_sel1[1] == ula_sel1[0]) allData = 1'b0;
    mop = {ula_sel1[1], ula_sel0[1]};
    case (mop)
      2'd0: begin
        mr = ma + mb;
        mv = (ma[W-1] == mb[W-1]) && (mr[W-1] != ma[W-1]);
      end
      2'd1: begin
        mr = ma - mb;
        mv = (ma[W-1] != mb[W-1]) && (mr[W-1] != ma[W-1]);
      end
      2'd2: begin
        mr = ma & mb;
        mv = forceOvf1;
      end
      default: begin
        mr = ma | mb;
        mv = forceOvf1;
      end
    endcase
    ula_res = '0;
    ula_ovf = '0;
    if (mode == 2'd3) begin
      ula_res = heldRes;
      ula_ovf = heldOvf;
    end else if (allData && mode != 2'd1) begin
      for (int i = 0; i < W; i++) begin
        ula_res[2*i+1] = mr[i];
        ula_res[2*i]   = ~mr[i];
      end
      ula_ovf = {mv, ~mv};
      if (mode == 2'd2) ula_res[5:4] = 2'b11;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and returns edges from accept to rsp_valid.
  task automatic doOp(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op, output int lat);
    req_a = a;
    req_b = b;
    req_op = op;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    int n;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 4) begin
      tick();
      n++;
    end
    check("req_ready_after_rsp", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int n;
    logic sawValid;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b0;
    mode = 2'd0;
    forceOvf1 = 1'b0;
    heldRes = '0;
    heldOvf = '0;

    tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_res", 32'(rsp_res), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_ula_a", 32'(ula_a), 32'd0);
    tick();
    rst_n = 1'b1;
    n = 0;
    while (!req_ready && n < 3) begin
      tick();
      n++;
    end
    check("flush_req_ready", 32'(req_ready), 32'd1);
    check("idle_ula", 32'({ula_a, ula_b, ula_sel0, ula_sel1}), 32'd0);

    doOp(4'b0111, 4'b0001, 2'b00, lat);
    check("add_lat", 32'(lat), 32'd6);
    check("add_res", 32'(rsp_res), 32'h8);
    check("add_ovf", 32'(rsp_ovf), 32'd1);
    check("add_err", 32'(rsp_err), 32'd0);
    rsp_ready = 1'b1;
    tick();
    check("add_rsp_drop", 32'(rsp_valid), 32'd0);
    check("add_rdy_e7", 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 1'b0;
    check("add_rdy_e8", 32'(req_ready), 32'd1);

    req_a = 4'b0111;
    req_b = 4'b0001;
    req_op = 2'b00;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("data_ula_a", 32'(ula_a), 32'h6A);
    check("data_ula_b", 32'(ula_b), 32'h56);
    check("data_sel", 32'({ula_sel1, ula_sel0}), 32'h5);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    check("null_ula_a", 32'(ula_a), 32'd0);
    consume();

    forceOvf1 = 1'b1;
    doOp(4'b1100, 4'b1010, 2'b10, lat);
    check("and_res", 32'(rsp_res), 32'h8);
    check("and_ovf", 32'(rsp_ovf), 32'd0);
    check("and_err", 32'(rsp_err), 32'd0);
    consume();
    forceOvf1 = 1'b0;

    mode = 2'd1;
    doOp(4'd3, 4'd4, 2'b00, lat);
    check("tmo_valid", 32'(rsp_valid), 32'd1);
    check("tmo_lat_ok", 32'(lat <= 19), 32'd1);
    check("tmo_err", 32'(rsp_err), 32'd1);
    check("tmo_res", 32'(rsp_res), 32'd0);
    mode = 2'd0;
    consume();
    doOp(4'd5, 4'd3, 2'b01, lat);
    check("sub_lat", 32'(lat), 32'd6);
    check("sub_res", 32'(rsp_res), 32'h2);
    check("sub_ovf", 32'(rsp_ovf), 32'd0);
    check("sub_err", 32'(rsp_err), 32'd0);
    consume();

    mode = 2'd2;
    doOp(4'b0101, 4'b0010, 2'b11, lat);
    check("ill_valid", 32'(rsp_valid), 32'd1);
    check("ill_err", 32'(rsp_err), 32'd1);
    check("ill_res", 32'(rsp_res), 32'd0);
    mode = 2'd0;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_fields", 32'({rsp_err, rsp_ovf, rsp_res}), 32'h20);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    consume();

    doOp(4'd1, 4'd1, 2'b00, lat);
    check("pre_reset_res", 32'(rsp_res), 32'h2);
    consume();
    req_a = 4'd1;
    req_b = 4'd1;
    req_op = 2'b00;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    heldRes = ula_res;
    heldOvf = ula_ovf;
    mode = 2'd3;
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_ula", 32'(ula_a), 32'd0);
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flush_hold_rdy", 32'(req_ready), 32'd0);
      sawValid |= rsp_valid;
    end
    mode = 2'd0;
    n = 0;
    while (!req_ready && n < 12) begin
      tick();
      sawValid |= rsp_valid;
      n++;
    end
    check("flush_done_rdy", 32'(req_ready), 32'd1);
    check("flush_no_rsp", 32'(sawValid), 32'd0);

    doOp(4'd2, 4'd3, 2'b00, lat);
    check("post_rst_lat", 32'(lat), 32'd6);
    check("post_rst_res", 32'(rsp_res), 32'h5);
    check("post_rst_err", 32'(rsp_err), 32'd0);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
